// File: rtl/inbound_fsm_mc.sv
// inbound_fsm_mc: multi-channel register file and upstream command/completion issue FSM.
// Completions and round-robin WR32 channel commands share one upstream FIFO.
module inbound_fsm_mc #(
    parameter int NUM_CH = 4,
    parameter logic [4:0] LEN_RST = 5'd6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en_i,
    input  logic [10:0] wr_addr_i,
    input  logic [31:0] wr_data_i,
    output logic        wr_busy_o,
    input  logic [10:0] rd_addr_i,
    output logic [31:0] rd_data_o,
    input  logic        req_compl_i,
    input  logic        req_compl_with_data_i,
    input  logic [2:0]  req_tc_i,
    input  logic        req_td_i,
    input  logic        req_ep_i,
    input  logic [1:0]  req_attr_i,
    input  logic [9:0]  req_len_i,
    input  logic [15:0] req_rid_i,
    input  logic [7:0]  req_tag_i,
    input  logic [7:0]  req_be_i,
    input  logic [12:0] req_addr_i,
    output logic        compl_done_o,
    input  logic        cmd_compl_i,
    input  logic [2:0]  cmd_id_i,
    input  logic        us_cmd_fifo_full_i,
    input  logic        us_cmd_fifo_prog_full_i,
    output logic [63:0] us_cmd_fifo_din_o,
    output logic        us_cmd_fifo_wr_en_o,
    output logic        rx_np_ok_o
);
    typedef enum logic [1:0] {IDLE, CPL_WAIT, ISSUE_CPL, ISSUE_CMD} state_t;
    localparam logic [7:0] CH_MASK = 8'((9'd1 << NUM_CH) - 9'd1);
    state_t state, state_nxt;
    logic [7:0] pending, busy;
    logic [1:0] err;
    logic [4:0] len;
    logic [31:0] addr [8];
    logic [2:0] rr, gnt, gnt_nxt;
    logic gnt_vld, cpld, idle, wr_ok, issue_cmd;
    logic [53:0] hdr;
    logic [3:0] widx;
    logic unused;
    assign unused = ^{wr_addr_i[10:6], wr_addr_i[1:0], rd_addr_i[10:6], rd_addr_i[1:0],
                      req_addr_i[12:7], req_addr_i[1:0]};
    assign idle = state == IDLE;
    assign issue_cmd = state == ISSUE_CMD;
    assign wr_ok = wr_en_i && idle;
    assign widx = wr_addr_i[5:2];
    assign wr_busy_o = !idle;
    assign rx_np_ok_o = idle && !us_cmd_fifo_prog_full_i;
    assign us_cmd_fifo_wr_en_o = issue_cmd || state == ISSUE_CPL;
    assign compl_done_o = state == ISSUE_CPL;
    assign us_cmd_fifo_din_o = issue_cmd ? {2'b10, len, gnt, 22'd0, addr[gnt]} :
                               compl_done_o ? {1'b0, cpld, len, 3'd0, hdr} : 64'd0;
    // Descending scan so the last hit is the first pending channel at or after rr.
    always_comb begin
        gnt_nxt = '0;
        gnt_vld = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--)
            if (pending[3'((int'(rr) + k) % NUM_CH)]) begin
                gnt_nxt = 3'((int'(rr) + k) % NUM_CH);
                gnt_vld = 1'b1;
            end
    end
    always_comb begin
        state_nxt = IDLE;
        if (idle)
            state_nxt = req_compl_i ? (us_cmd_fifo_full_i ? CPL_WAIT : ISSUE_CPL) :
                        (gnt_vld && !us_cmd_fifo_full_i) ? ISSUE_CMD : IDLE;
        else if (state == CPL_WAIT)
            state_nxt = us_cmd_fifo_full_i ? CPL_WAIT : ISSUE_CPL;
    end
    always_comb begin
        rd_data_o = '0;
        if (rd_addr_i[5])
            rd_data_o = int'(rd_addr_i[4:2]) < NUM_CH ? addr[rd_addr_i[4:2]] : 32'd0;
        else if (rd_addr_i[4:2] == 3'd0)
            rd_data_o = 32'(pending);
        else if (rd_addr_i[4:2] == 3'd1)
            rd_data_o = 32'(len);
        else if (rd_addr_i[4:2] == 3'd2)
            rd_data_o = 32'(busy);
        else if (rd_addr_i[4:2] == 3'd3)
            rd_data_o = 32'(err);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pending <= '0;
            busy <= '0;
            err <= '0;
            len <= LEN_RST;
            rr <= '0;
            gnt <= '0;
            cpld <= 1'b0;
            hdr <= '0;
            for (int c = 0; c < 8; c++) addr[c] <= '0;
        end else begin
            state <= state_nxt;
            if (idle && req_compl_i) begin
                cpld <= req_compl_with_data_i;
                hdr <= {req_tc_i, req_td_i, req_ep_i, req_attr_i, req_len_i, req_rid_i,
                        req_tag_i, req_be_i, req_addr_i[6:2]};
            end
            if (state_nxt == ISSUE_CMD) gnt <= gnt_nxt;
            if (issue_cmd) rr <= int'(gnt) == NUM_CH - 1 ? 3'd0 : gnt + 3'd1;
            if (wr_ok && widx == 4'd1) len <= wr_data_i[4:0];
            if (wr_ok && wr_addr_i[5] && int'(wr_addr_i[4:2]) < NUM_CH)
                addr[wr_addr_i[4:2]] <= wr_data_i;
            // CMD writes test the busy value before any same-cycle completion clears it.
            pending <= (pending | (wr_ok && widx == 4'd0 ? wr_data_i[7:0] & CH_MASK & ~busy : 8'd0))
                       & ~(issue_cmd ? 8'd1 << gnt : 8'd0);
            busy <= (busy & ~(cmd_compl_i && busy[cmd_id_i] ? 8'd1 << cmd_id_i : 8'd0))
                    | (issue_cmd ? 8'd1 << gnt : 8'd0);
            err <= (err & ~(wr_ok && widx == 4'd3 ? wr_data_i[1:0] : 2'd0))
                   | {wr_en_i && !idle, cmd_compl_i && !busy[cmd_id_i]};
        end
    end
endmodule

// File: tb/tb_inbound_fsm_mc.sv
// tb_inbound_fsm_mc: randomized check of inbound_fsm_mc against a transaction-level model,
// with directed scenarios pinning literal values.
module tb_inbound_fsm_mc;
    localparam int NUM_CH = 4;
    logic clk = 0, rst = 1;
    logic wr_en = 0, req = 0, cpld = 0, td = 0, ep = 0, cmd_compl = 0, full = 0, pfull = 0;
    logic [10:0] wr_addr = 0, rd_addr = 0;
    logic [31:0] wr_data = 0;
    logic [2:0] tc = 0, cmd_id = 0;
    logic [1:0] attr = 0;
    logic [9:0] rlen = 0;
    logic [15:0] rid = 0;
    logic [7:0] tag = 0, be = 0;
    logic [12:0] raddr = 0;
    logic wr_busy, compl_done, fifo_wr, np_ok;
    logic [31:0] rd_data;
    logic [63:0] din;
    int n_chk = 0, n_fail = 0;
    bit chk_on = 0;

    inbound_fsm_mc #(.NUM_CH(NUM_CH), .LEN_RST(5'd6)) dut (
        .clk(clk), .rst(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_busy_o(wr_busy), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
        .req_compl_i(req), .req_compl_with_data_i(cpld), .req_tc_i(tc), .req_td_i(td),
        .req_ep_i(ep), .req_attr_i(attr), .req_len_i(rlen), .req_rid_i(rid), .req_tag_i(tag),
        .req_be_i(be), .req_addr_i(raddr), .compl_done_o(compl_done), .cmd_compl_i(cmd_compl),
        .cmd_id_i(cmd_id), .us_cmd_fifo_full_i(full), .us_cmd_fifo_prog_full_i(pfull),
        .us_cmd_fifo_din_o(din), .us_cmd_fifo_wr_en_o(fifo_wr), .rx_np_ok_o(np_ok));

    always #5 clk = ~clk;

    // Model: the block is "occupied" while a completion waits for space or a FIFO write is
    // happening this cycle; the write contents are recorded as a transaction.
    bit [7:0] m_pend, m_busy;
    bit [1:0] m_err;
    bit [4:0] m_len = 6;
    bit [31:0] m_addr [8];
    int m_rr, m_ch;
    bit m_wait, m_wr, m_wr_cmd, m_cpld;
    bit [53:0] m_hdr;

    always @(posedge clk) begin
        bit [7:0] ob, op;
        bit idle, nw, nc;
        int g;
        if (rst) begin
            m_pend = 0; m_busy = 0; m_err = 0; m_len = 6; m_rr = 0; m_ch = 0;
            m_wait = 0; m_wr = 0; m_wr_cmd = 0; m_cpld = 0; m_hdr = 0;
            for (int c = 0; c < 8; c++) m_addr[c] = 0;
        end else begin
            ob = m_busy; op = m_pend;
            idle = !m_wait && !m_wr;
            nw = 0; nc = 0; g = 0;
            if (m_wait) begin
                if (!full) begin nw = 1; m_wait = 0; end
            end else if (idle) begin
                if (req) begin
                    m_cpld = cpld;
                    m_hdr = {tc, td, ep, attr, rlen, rid, tag, be, raddr[6:2]};
                    if (full) m_wait = 1; else nw = 1;
                end else if (op != 0 && !full) begin
                    for (int k = NUM_CH - 1; k >= 0; k--)
                        if (op[(m_rr + k) % NUM_CH]) g = (m_rr + k) % NUM_CH;
                    nw = 1; nc = 1;
                end
            end
            if (wr_en && idle) begin
                case (int'(wr_addr[5:2]))
                    0: for (int c = 0; c < NUM_CH; c++) if (wr_data[c] && !ob[c]) m_pend[c] = 1;
                    1: m_len = wr_data[4:0];
                    3: m_err = m_err & ~wr_data[1:0];
                    default: if (wr_addr[5] && wr_addr[4:2] < NUM_CH) m_addr[wr_addr[4:2]] = wr_data;
                endcase
            end
            if (wr_en && !idle) m_err[1] = 1;
            if (cmd_compl) begin
                if (ob[cmd_id]) m_busy[cmd_id] = 0; else m_err[0] = 1;
            end
            if (m_wr && m_wr_cmd) begin
                m_pend[m_ch] = 0; m_busy[m_ch] = 1; m_rr = (m_ch + 1) % NUM_CH;
            end
            m_wr = nw; m_wr_cmd = nc;
            if (nc) m_ch = g;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [10:0] a);
        if (a[5]) return a[4:2] < NUM_CH ? m_addr[a[4:2]] : 32'd0;
        case (int'(a[4:2]))
            0: return 32'(m_pend);
            1: return 32'(m_len);
            2: return 32'(m_busy);
            3: return 32'(m_err);
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", n, $time, a, e);
        end
    endtask

    always @(negedge clk) if (chk_on) begin
        logic [63:0] ed;
        ed = !m_wr ? 64'd0 : m_wr_cmd ? {2'b10, m_len, 3'(m_ch), 22'd0, m_addr[m_ch]}
                                      : {1'b0, m_cpld, m_len, 3'd0, m_hdr};
        chk("wr_en", 64'(fifo_wr), 64'(m_wr));
        chk("din", din, ed);
        chk("compl_done", 64'(compl_done), 64'(m_wr && !m_wr_cmd));
        chk("wr_busy", 64'(wr_busy), 64'(m_wait || m_wr));
        chk("rx_np_ok", 64'(np_ok), 64'(!(m_wait || m_wr) && !pfull));
        chk("rd_data", 64'(rd_data), 64'(exp_rd(rd_addr)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d);
        wr_en = 1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 0;
    endtask

    initial begin
        tick();
        rst = 0; chk_on = 1;
        rd_addr = 11'h04;
        @(negedge clk);
        chk("rst_len", 64'(rd_data), 64'd6);
        chk("rst_busy", 64'(wr_busy), 64'd0);
        wr(11'h28, 32'h1000_0040);
        wr(11'h00, 32'h4);
        tick();
        @(negedge clk);
        chk("t1_wr", 64'(fifo_wr), 64'd1);
        chk("t1_din", din, 64'h8C80_0000_1000_0040);
        tick();
        rd_addr = 11'h08;
        @(negedge clk);
        chk("t1_state", 64'(rd_data), 64'h4);
        full = 1; req = 1; cpld = 1; tag = 8'h5A;
        tick();
        req = 0;
        @(negedge clk);
        chk("t3_busy", 64'(wr_busy), 64'd1);
        chk("t3_nowr", 64'(fifo_wr), 64'd0);
        tick();
        full = 0;
        tick();
        @(negedge clk);
        chk("t3_din", din, {2'b01, 5'd6, 3'd0, 54'(8'h5A) << 13});
        chk("t3_done", 64'(compl_done), 64'd1);
        tick();
        @(negedge clk);
        chk("t3_done_off", 64'(compl_done), 64'd0);
        cmd_compl = 1; cmd_id = 3;
        tick();
        cmd_compl = 0; rd_addr = 11'h0C;
        @(negedge clk);
        chk("t5_err", 64'(rd_data), 64'd1);
        wr(11'h0C, 32'h1);
        @(negedge clk);
        chk("t5_err_clr", 64'(rd_data), 64'd0);
        cmd_compl = 1; cmd_id = 2;
        tick();
        cmd_compl = 0; rd_addr = 11'h08;
        @(negedge clk);
        chk("t2_state", 64'(rd_data), 64'd0);
        wr(11'h00, 32'h1);
        tick();
        wr(11'h04, 32'h1F);
        rd_addr = 11'h04;
        @(negedge clk);
        chk("t6_len", 64'(rd_data), 64'd6);
        rd_addr = 11'h0C;
        #1;
        chk("t6_err", 64'(rd_data), 64'd2);
        full = 1; req = 1;
        tick();
        req = 0; rst = 1;
        tick();
        rst = 0; full = 0; rd_addr = 11'h08;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_rst_nowr", 64'(fifo_wr), 64'd0);
            chk("t6_rst_state", 64'(rd_data), 64'd0);
            tick();
        end
        for (int i = 0; i < 4000; i++) begin
            rst = $urandom_range(0, 399) == 0;
            wr_en = $urandom_range(0, 2) == 0;
            wr_addr = {5'($urandom), $urandom_range(0, 1) ? 4'd0 : 4'($urandom), 2'($urandom)};
            wr_data = $urandom;
            rd_addr = 11'($urandom);
            req = $urandom_range(0, 5) == 0;
            cpld = 1'($urandom);
            {tc, td, ep, attr, rlen} = 17'($urandom);
            {rid, tag, be} = 32'($urandom);
            raddr = 13'($urandom);
            cmd_compl = $urandom_range(0, 4) == 0;
            cmd_id = $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'($urandom_range(0, NUM_CH - 1));
            full = $urandom_range(0, 3) == 0;
            pfull = $urandom_range(0, 3) == 0;
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
